// File: rtl/lvds_bus_target.sv
// lvds_bus_target: queues decoded link words and executes them on the local register bus,
// returning read data, ping echoes and read timeouts as paced response words.
module lvds_bus_target #(
  parameter int FIFO_DEPTH = 4,
  parameter int TX_GAP     = 11,
  parameter int RD_TIMEOUT = 255
) (
  input  logic        c_i,
  input  logic        r_i,
  input  logic [41:0] rx_d_i,
  input  logic        rx_v_i,
  output logic [41:0] tx_d_o,
  output logic        tx_v_o,
  output logic        wr_o,
  output logic        rd_o,
  output logic [7:0]  addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  input  logic        rvalid_i,
  output logic        ovf_o,
  output logic        bad_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] GAP_LD = 16'(TX_GAP - 1);
  localparam logic [15:0] TMO_LD = 16'(RD_TIMEOUT);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [41:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic [41:0] head, resp_q, resp_d, tx_d_q, tx_d_d;
  logic [15:0] tmo_q, tmo_d, gap_q, gap_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic tx_v_q, tx_v_d, wr_q, wr_d, rd_q, rd_d, ovf_q, ovf_d, bad_q, bad_d;
  logic full, empty, push, pop;
  assign empty = wptr_q == rptr_q;
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push  = rx_v_i && !full;
  assign pop   = (state_q == IDLE) && !empty;
  assign head  = mem_q[rptr_q[AW-1:0]];
  assign tx_d_o  = tx_d_q;
  assign tx_v_o  = tx_v_q;
  assign wr_o    = wr_q;
  assign rd_o    = rd_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign ovf_o   = ovf_q;
  assign bad_o   = bad_q;
  always_ff @(posedge c_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= rx_d_i;
  end
  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    tmo_d   = tmo_q;
    gap_d   = (gap_q == 16'd0) ? 16'd0 : gap_q - 16'd1;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tx_d_d  = tx_d_q;
    tx_v_d  = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    ovf_d   = ovf_q | (rx_v_i & full);
    bad_d   = bad_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          case (head[41:40])
            2'b00: begin
              addr_d  = head[39:32];
              wdata_d = head[31:0];
              wr_d    = 1'b1;
            end
            2'b01: begin
              addr_d  = head[39:32];
              rd_d    = 1'b1;
              tmo_d   = TMO_LD;
              state_d = RD_WAIT;
            end
            2'b10: begin
              resp_d  = head;
              state_d = RESP;
            end
            default: bad_d = 1'b1;
          endcase
        end
      end
      RD_WAIT: begin
        // data arriving on the expiry edge still wins over the timeout
        if (rvalid_i) begin
          resp_d  = {2'b01, addr_q, rdata_i};
          state_d = RESP;
        end else if (tmo_q <= 16'd1) begin
          resp_d  = {2'b11, addr_q, 32'h0};
          state_d = RESP;
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
      end
      RESP: begin
        if (gap_q == 16'd0) begin
          tx_d_d  = resp_q;
          tx_v_d  = 1'b1;
          gap_d   = GAP_LD;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge c_i) begin
    if (!r_i) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      resp_q  <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tx_d_q  <= '0;
      tx_v_q  <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_q + {{AW{1'b0}}, push};
      rptr_q  <= rptr_q + {{AW{1'b0}}, pop};
      resp_q  <= resp_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tx_d_q  <= tx_d_d;
      tx_v_q  <= tx_v_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end
endmodule
